// File: rtl/d_sram_like_to_axi_pkg.sv
// Shared definitions for the sram-like to AXI3 bridges: FSM encoding,
// fixed AXI field values, port IDs and the write-strobe helper.
package d_sram_like_to_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic [3:0] INST_PORT_ID = 4'd0;
  localparam logic [3:0] DATA_PORT_ID = 4'd1;

  // Byte-lane strobe for a single-beat access; size 3 is illegal and is
  // treated as a full word so a bad request never produces an empty strobe.
  function automatic logic [3:0] sram_wstrb(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/d_sram_like_to_axi.sv
// Data-side sram-like responder: turns one request at a time into a
// single-beat AXI3 read or write and answers with a one-cycle data_ok.
module d_sram_like_to_axi
  import d_sram_like_to_axi_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = ID_W'(DATA_PORT_ID)
) (
  input  logic            clk,
  input  logic            rst,
  // sram-like side
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic [31:0]     data_rdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  // AXI read address
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  // AXI read data
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AXI write address
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  // AXI write data
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI write response
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  state_t      state_reg, state_next;
  logic        aw_done_reg, aw_done_next;
  logic        w_done_reg, w_done_next;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  strb_reg;
  logic        aw_fire, w_fire;

  // Response IDs, status and rlast are not needed: only one transaction is
  // ever outstanding and every access is a single beat.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, wr_reg};

  // Handshake-level outputs are pure decodes of the state and done flags.
  assign data_addr_ok = (state_reg == IDLE) && data_req;
  assign data_data_ok = ((state_reg == RD_DATA) && rvalid) ||
                        ((state_reg == WR_RESP) && bvalid);
  assign data_rdata   = rdata;

  assign arvalid = (state_reg == RD_ADDR);
  assign rready  = (state_reg == RD_DATA);
  assign awvalid = (state_reg == WR_REQ) && !aw_done_reg;
  assign wvalid  = (state_reg == WR_REQ) && !w_done_reg;
  assign bready  = (state_reg == WR_RESP);

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  // Channel fields come straight from the latched request.
  assign arid    = AXI_ID;
  assign araddr  = addr_reg;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_reg};
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = AXI_ID;
  assign awaddr  = addr_reg;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, size_reg};
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = AXI_ID;
  assign wdata   = wdata_reg;
  assign wstrb   = strb_reg;
  assign wlast   = 1'b1;

  // Next-state and write-channel completion tracking.
  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg || aw_fire;
    w_done_next  = w_done_reg || w_fire;
    case (state_reg)
      IDLE: begin
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        if (data_req) state_next = data_wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: if (arready) state_next = RD_DATA;
      RD_DATA: if (rvalid)  state_next = IDLE;
      WR_REQ:  if (aw_done_next && w_done_next) state_next = WR_RESP;
      WR_RESP: if (bvalid)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and done flags; reset drops any in-flight transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  // Capture the request on acceptance; fields stay frozen until next IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_reg    <= 1'b0;
      size_reg  <= 2'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      strb_reg  <= 4'd0;
    end else if (data_addr_ok) begin
      wr_reg    <= data_wr;
      size_reg  <= data_size;
      addr_reg  <= data_addr;
      wdata_reg <= data_wdata;
      strb_reg  <= sram_wstrb(data_size, data_addr[1:0]);
    end
  end

endmodule

// File: tb/tb_d_sram_like_to_axi.sv
// Self-checking bench for d_sram_like_to_axi: a delay-programmable AXI slave,
// a negedge monitor with a scoreboard queue, and directed transactions.
module tb_d_sram_like_to_axi;
  import d_sram_like_to_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  d_sram_like_to_axi dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference strobe table.
  function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    case ({size, a})
      4'b0000: s = 4'b0001;
      4'b0001: s = 4'b0010;
      4'b0010: s = 4'b0100;
      4'b0011: s = 4'b1000;
      4'b0100, 4'b0101: s = 4'b0011;
      4'b0110, 4'b0111: s = 4'b1100;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  strb;
  } exp_t;
  exp_t exp_q[$];

  // Slave timing knobs and read data.
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] rd_val = 32'h0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  // Cycle counter and monitor statistics.
  int cyc = 0;
  int ar_cycles, aw_cycles, w_cycles, ok_cnt;
  int ar_first, bready_first, aw_hs_cyc;
  bit ar_seen, bready_seen;
  int last_t0, last_t1;

  always @(posedge clk) cyc <= cyc + 1;

  // AXI slave: readies/valids decided just after each rising edge.
  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = 0; rid = 4'd1; rresp = 2'd0; rlast = 1'b1; bid = 4'd1; bresp = 2'd0;
    forever begin
      @(posedge clk); #1;
      if (arvalid) begin arready = (ar_cnt == ar_delay); ar_cnt = arready ? 0 : ar_cnt + 1; end
      else begin arready = 0; ar_cnt = 0; end
      if (awvalid) begin awready = (aw_cnt == aw_delay); aw_cnt = awready ? 0 : aw_cnt + 1; end
      else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt == w_delay); w_cnt = wready ? 0 : w_cnt + 1; end
      else begin wready = 0; w_cnt = 0; end
      if (rready) begin
        rvalid = (r_cnt == r_delay); r_cnt = rvalid ? 0 : r_cnt + 1;
        rdata = rvalid ? rd_val : 32'h5A5A_5A5A;
      end else begin rvalid = 0; r_cnt = 0; rdata = 32'h5A5A_5A5A; end
      if (bready) begin bvalid = (b_cnt == b_delay); b_cnt = bvalid ? 0 : b_cnt + 1; end
      else begin bvalid = 0; b_cnt = 0; end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (data_addr_ok)
        exp_q.push_back('{data_wr, data_size, data_addr, data_wdata, rd_val,
                          exp_strb(data_size, data_addr[1:0])});
      if (arvalid) begin
        ar_cycles++;
        if (!ar_seen) begin ar_first = cyc; ar_seen = 1; end
        check_eq("ar_aw_overlap", 32'(awvalid), 32'd0);
        if (arready) begin
          if (exp_q.size() == 0) check_eq("ar_unexpected", 32'(arvalid), 32'd0);
          else begin
            check_eq("araddr", araddr, exp_q[0].addr);
            check_eq("arsize", 32'(arsize), 32'({1'b0, exp_q[0].size}));
            check_eq("ar_fixed", 32'({arid, arlen, arburst, arlock, arcache, arprot}),
                     32'({4'd1, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0}));
          end
        end
      end
      if (awvalid) begin
        aw_cycles++;
        if (awready) begin
          aw_hs_cyc = cyc;
          if (exp_q.size() == 0) check_eq("aw_unexpected", 32'(awvalid), 32'd0);
          else begin
            check_eq("awaddr", awaddr, exp_q[0].addr);
            check_eq("awsize", 32'(awsize), 32'({1'b0, exp_q[0].size}));
            check_eq("aw_fixed", 32'({awid, awlen, awburst, awlock, awcache, awprot}),
                     32'({4'd1, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0}));
          end
        end
      end
      if (wvalid) begin
        w_cycles++;
        if (wready) begin
          if (exp_q.size() == 0) check_eq("w_unexpected", 32'(wvalid), 32'd0);
          else begin
            check_eq("wstrb", 32'(wstrb), 32'(exp_q[0].strb));
            check_eq("wdata", wdata, exp_q[0].wdata);
            check_eq("wlast_wid", 32'({wlast, wid}), 32'({1'b1, 4'd1}));
          end
        end
      end
      if (bready && !bready_seen) begin bready_first = cyc; bready_seen = 1; end
      if (data_data_ok) begin
        ok_cnt++;
        check_eq("ok_vs_addr_ok", 32'(data_addr_ok), 32'd0);
        if (exp_q.size() == 0) check_eq("ok_unexpected", 32'(data_data_ok), 32'd0);
        else begin
          if (exp_q[0].wr) check_eq("ok_with_bvalid", 32'(bvalid), 32'd1);
          else             check_eq("rdata", data_rdata, exp_q[0].rdata);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic clear_stats();
    ar_cycles = 0; aw_cycles = 0; w_cycles = 0; ok_cnt = 0;
    ar_seen = 0; bready_seen = 0; ar_first = -1; bready_first = -1; aw_hs_cyc = -1;
  endtask

  task automatic wait_addr_ok(output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_addr_ok) begin c = cyc; break; end
    end
    if (c < 0) check_eq("addr_ok_timeout", 32'(data_addr_ok), 32'd1);
  endtask

  task automatic wait_data_ok(output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_data_ok) begin c = cyc; break; end
    end
    if (c < 0) check_eq("data_ok_timeout", 32'(data_data_ok), 32'd1);
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wd);
    data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
  endtask

  // One complete transaction with the request dropped after acceptance.
  task automatic run_txn(input string name, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input int exp_lat);
    clear_stats();
    @(posedge clk); #1;
    drive_req(wr, size, addr, wd);
    wait_addr_ok(last_t0);
    @(posedge clk); #1;
    data_req = 0;
    wait_data_ok(last_t1);
    check_eq({name, "_latency"}, 32'(last_t1 - last_t0), 32'(exp_lat));
    repeat (3) @(posedge clk);
    check_eq({name, "_ok_count"}, 32'(ok_cnt), 32'd1);
    $display("txn %s wr=%0d size=%0d addr=%h latency=%0d", name, wr, size, addr, last_t1 - last_t0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, oks;
    rst = 1; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_eq("reset_handshakes",
             32'({arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}), 32'd0);
    check_eq("reset_latched", araddr | awaddr | wdata | 32'(wstrb) | 32'(arsize), 32'd0);
    @(posedge clk); #1; rst = 0;
    repeat (2) @(posedge clk);

    // Word read, zero-wait slave.
    rd_val = 32'hDEAD_BEEF;
    run_txn("read_word", 1'b0, 2'd2, 32'h1FC0_0004, 32'h0, 2);
    check_eq("read_ar_cycle", 32'(ar_first - last_t0), 32'd1);

    // Byte write to the top lane.
    run_txn("write_byte3", 1'b1, 2'd0, 32'h8000_0003, 32'hAA00_0000, 2);

    // Strobe sweep over byte offsets, half-words and the illegal size.
    for (int i = 0; i < 4; i++)
      run_txn("write_byte", 1'b1, 2'd0, 32'h0000_1000 + 32'(i), 32'h1122_3344, 2);
    run_txn("write_half_lo", 1'b1, 2'd1, 32'h0000_2000, 32'h0000_BEEF, 2);
    run_txn("write_half_hi", 1'b1, 2'd1, 32'h0000_2002, 32'hBEEF_0000, 2);
    run_txn("write_size3", 1'b1, 2'd3, 32'h0000_2003, 32'hCAFE_F00D, 2);

    // AW delayed three cycles, W immediate.
    aw_delay = 3;
    run_txn("write_aw_slow", 1'b1, 2'd2, 32'h0000_3000, 32'h0BAD_CAFE, 5);
    check_eq("aw_slow_awvalid_cycles", 32'(aw_cycles), 32'd4);
    check_eq("aw_slow_wvalid_cycles", 32'(w_cycles), 32'd1);
    check_eq("aw_slow_resp_after_aw", 32'(bready_first - aw_hs_cyc), 32'd1);
    aw_delay = 0;

    // W delayed, AW immediate: mirror ordering.
    w_delay = 2;
    run_txn("write_w_slow", 1'b1, 2'd2, 32'h0000_3004, 32'h1357_9BDF, 4);
    check_eq("w_slow_awvalid_cycles", 32'(aw_cycles), 32'd1);
    check_eq("w_slow_wvalid_cycles", 32'(w_cycles), 32'd3);
    w_delay = 0;

    // Same-cycle AW/W handshakes, bvalid two cycles into WR_RESP.
    b_delay = 2;
    run_txn("write_b_slow", 1'b1, 2'd2, 32'h0000_4000, 32'h2468_ACE0, 4);
    check_eq("b_slow_wr_req_cycles", 32'(aw_cycles), 32'd1);
    check_eq("b_slow_bready_cycle", 32'(bready_first - last_t0), 32'd2);
    b_delay = 0;

    // Slow read data.
    r_delay = 3; rd_val = 32'h0F0F_1234;
    run_txn("read_slow", 1'b0, 2'd1, 32'h0000_5002, 32'h0, 5);
    r_delay = 0;

    // Back-to-back read then write with data_req held high.
    clear_stats();
    rd_val = 32'h1234_5678;
    @(posedge clk); #1;
    drive_req(1'b0, 2'd2, 32'h0000_0040, 32'h0);
    wait_addr_ok(t0);
    @(posedge clk); #1;
    drive_req(1'b1, 2'd1, 32'h0000_0042, 32'hBEEF_0000);
    wait_data_ok(t1);
    wait_addr_ok(t2);
    @(posedge clk); #1;
    data_req = 0;
    wait_data_ok(t3);
    check_eq("b2b_read_latency", 32'(t1 - t0), 32'd2);
    check_eq("b2b_second_addr_ok", 32'(t2 - t1), 32'd1);
    check_eq("b2b_write_latency", 32'(t3 - t2), 32'd2);
    repeat (3) @(posedge clk);
    check_eq("b2b_ok_count", 32'(ok_cnt), 32'd2);
    $display("txn b2b read@%0d write@%0d data_ok@%0d,%0d", t0, t2, t1, t3);

    // Reset while waiting for read data.
    clear_stats();
    r_delay = 20;
    @(posedge clk); #1;
    drive_req(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    wait_addr_ok(t0);
    @(posedge clk); #1;
    data_req = 0;
    t1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rready) begin t1 = cyc; break; end
    end
    check_eq("abort_reached_rd_data", 32'(rready), 32'd1);
    #2; rst = 1; #1;
    check_eq("abort_handshakes",
             32'({arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}), 32'd0);
    check_eq("abort_state", 32'(dut.state_reg), 32'(IDLE));
    oks = ok_cnt;
    repeat (3) @(posedge clk); #1; rst = 0;
    repeat (10) @(posedge clk);
    check_eq("abort_no_data_ok", 32'(ok_cnt), 32'(oks));
    $display("txn abort read addr=00000100 reset at cycle %0d", t1);
    r_delay = 0;

    // Recovery after the abort.
    rd_val = 32'h7654_3210;
    run_txn("read_after_reset", 1'b0, 2'd2, 32'h0000_0200, 32'h0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
